sprite_draw_scheduler: RTL
==========================

SPRITE_DRAW_SCHEDULER -- requirements
Module: sprite_draw_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): XSCREEN, 160, screen width in pixels.
REQ-002 The block SHALL have parameter YSCREEN, 120, screen height in pixels.
REQ-003 The block SHALL have parameters SPR_W and SPR_H, both 30, sprite width and height in pixels.
REQ-004 The block SHALL have parameter TRANSPARENT, 3'b101, the sprite colour key that is never plotted.
REQ-005 CLOCK_50  input  1  single system clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req  input  2  per-requester draw request; bit i is held high until ack[i].
REQ-008 req_x  input  16  new X position; requester i uses bits [8i+7:8i].
REQ-009 req_y  input  14  new Y position; requester i uses bits [7i+6:7i].
REQ-010 ack  output  2  one-cycle completion pulse per requester.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 spr_id  output  1  index of the granted requester; selects the sprite ROM.
REQ-013 spr_addr  output  10  sprite ROM address, computed as row*SPR_W+col.
REQ-014 spr_q  input  3  sprite ROM data, one cycle after spr_addr.
REQ-015 bg_addr  output  15  background ROM address, computed as y*XSCREEN+x.
REQ-016 bg_q  input  3  background ROM data, one cycle after bg_addr.
REQ-017 vga_x  output  8  plot X coordinate, to the VGA adapter x port.
REQ-018 vga_y  output  7  plot Y coordinate, to the VGA adapter y port.
REQ-019 vga_colour  output  3  plot colour.
REQ-020 vga_plot  output  1  plot write enable.

Function
REQ-021 The FSM SHALL use the states IDLE, ERASE, DRAW and DONE.
REQ-022 In IDLE, if req is nonzero, the block SHALL grant one requester round-robin: the requester holding the priority pointer wins on a tie, otherwise the single requester wins.
REQ-023 On the grant cycle G, the block SHALL latch the granted index and that requester's req_x/req_y; later changes to those inputs SHALL be ignored until ack.
REQ-024 From IDLE the FSM SHALL go to ERASE if prev_valid[i] is set, otherwise to DRAW.
REQ-025 ERASE SHALL sweep a 10-bit column/row counter row-major over SPR_W*SPR_H = 900 pixels at the stored previous position of requester i, issuing one bg_addr per cycle.
REQ-026 One cycle after each ERASE address, the plot stage SHALL drive the registered pixel coordinate, set vga_colour to bg_q, and assert vga_plot.
REQ-027 DRAW SHALL sweep 900 pixels at the latched new position, issuing one spr_addr per cycle.
REQ-028 One cycle after each DRAW address, vga_colour SHALL equal spr_q, and vga_plot SHALL be asserted only if spr_q != TRANSPARENT.
REQ-029 Any pixel with X >= XSCREEN or Y >= YSCREEN SHALL be clipped: the counter still advances but vga_plot stays 0 for that pixel.
REQ-030 Coordinate sums SHALL be computed 9 bits wide before the clip compare, so there is no wrap-around on screen edges.
REQ-031 Phases SHALL be contiguous with erase performed: ERASE addresses at G+1..G+900, DRAW addresses at G+901..G+1800, and last plot at G+1801.
REQ-032 With erase performed, DONE SHALL occur at G+1802, and ack[i] SHALL be high for exactly that cycle.
REQ-033 With erase skipped, DRAW addresses SHALL occur at G+1..G+900, and ack[i] SHALL be high at G+902.
REQ-034 In DONE, the block SHALL store prev_x[i]/prev_y[i] from the latched position, set prev_valid[i], move the priority pointer to the other requester, and return to IDLE.
REQ-035 The next grant SHALL be possible at the cycle after DONE.
REQ-036 vga_plot SHALL be 0 in IDLE and in DONE.
REQ-037 Deasserting req[i] mid-operation SHALL NOT abort the operation; ack[i] SHALL still pulse.

Reset
REQ-038 While reset is high, the FSM SHALL be in IDLE.
REQ-039 While reset is high, ack, busy and vga_plot SHALL be 0, vga_x/vga_y/vga_colour SHALL be 0, and spr_addr/bg_addr/spr_id SHALL be 0.
REQ-040 While reset is high, prev_valid SHALL be 2'b00, and the priority pointer SHALL favour requester 0.
REQ-041 Reset asserted mid-operation SHALL take effect immediately and asynchronously; the aborted requester SHALL receive no ack.

Verification
REQ-042 After reset, req=2'b01 with x=20, y=0 -> no erase; 900 DRAW plots in the rectangle x 20..49, y 0..29; ack[0] at G+902.
REQ-043 Second request from requester 0 with x=21, y=1 -> 900 erase plots at (20,0) with bg_q colours, then draw at (21,1); ack[0] at G+1802.
REQ-044 req=2'b11 after reset -> requester 0 is served first, then requester 1 with no IDLE bubble beyond one cycle; next tie goes to requester 1.
REQ-045 Request with x=150, y=110 -> only x 150..159 and y 110..119 are plotted (100 pixels max); ack timing is unchanged.
REQ-046 Sprite ROM returning TRANSPARENT for every even address -> vga_plot is low on exactly those plot cycles.
REQ-047 Reset asserted at G+500 -> vga_plot, busy and ack are 0 in that same cycle; the next request takes the no-erase path.

Source files
------------

// File: rtl/sprite_draw_scheduler.sv
// Two-requester sprite mover: erases a sprite's previous footprint from the background
// ROM, then redraws it from the sprite ROM at the new position, one pixel per clock.
module sprite_draw_scheduler #(
  parameter int         XSCREEN     = 160,
  parameter int         YSCREEN     = 120,
  parameter int         SPR_W       = 30,
  parameter int         SPR_H       = 30,
  parameter logic [2:0] TRANSPARENT = 3'b101
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [15:0] req_x,
  input  logic [13:0] req_y,
  output logic [1:0]  ack,
  output logic        busy,
  output logic        spr_id,
  output logic [9:0]  spr_addr,
  input  logic [2:0]  spr_q,
  output logic [14:0] bg_addr,
  input  logic [2:0]  bg_q,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  localparam logic [9:0]  SPR_W10 = 10'(SPR_W);
  localparam logic [9:0]  SPR_H10 = 10'(SPR_H);
  localparam logic [8:0]  XS9     = 9'(XSCREEN);
  localparam logic [8:0]  YS9     = 9'(YSCREEN);
  localparam logic [14:0] XS15    = 15'(XSCREEN);

  state_t      state, next_state;
  logic        idx;
  logic        prio;
  logic [7:0]  cur_x;
  logic [6:0]  cur_y;
  logic [7:0]  prev_x [2];
  logic [6:0]  prev_y [2];
  logic [1:0]  prev_valid;
  logic [9:0]  col, row;

  logic        plot_valid, plot_erase, plot_clip;
  logic [7:0]  plot_x;
  logic [6:0]  plot_y;

  logic        grant_idx;
  logic        last_pix, flush, sweeping, clip;
  logic [7:0]  base_x;
  logic [6:0]  base_y;
  logic [8:0]  px, py;

  // The requester holding the priority pointer only matters when both are asking.
  assign grant_idx = (req == 2'b11) ? prio : req[1];

  assign last_pix = (col == SPR_W10 - 10'd1) && (row == SPR_H10 - 10'd1);
  // Row parked one past the sprite marks the final cycle where only the last plot drains.
  assign flush    = (state == DRAW) && (row == SPR_H10);
  assign sweeping = (state == ERASE) || ((state == DRAW) && !flush);

  assign base_x = (state == ERASE) ? prev_x[idx] : cur_x;
  assign base_y = (state == ERASE) ? prev_y[idx] : cur_y;
  assign px     = {1'b0, base_x} + col[8:0];
  assign py     = {2'b00, base_y} + row[8:0];
  assign clip   = (px >= XS9) || (py >= YS9);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    ack        = 2'b00;
    unique case (state)
      IDLE:  if (req != 2'b00) next_state = prev_valid[grant_idx] ? ERASE : DRAW;
      ERASE: if (last_pix) next_state = DRAW;
      DRAW:  if (flush) next_state = DONE;
      DONE: begin
        next_state = IDLE;
        ack        = idx ? 2'b10 : 2'b01;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    spr_addr = 10'd0;
    bg_addr  = 15'd0;
    if (state == ERASE)
      bg_addr = 15'(py) * XS15 + 15'(px);
    if ((state == DRAW) && !flush)
      spr_addr = row * SPR_W10 + col;
  end

  assign busy   = (state != IDLE);
  assign spr_id = idx;

  // Request latching, pixel counters and per-requester history.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      idx        <= 1'b0;
      prio       <= 1'b0;
      cur_x      <= 8'd0;
      cur_y      <= 7'd0;
      prev_valid <= 2'b00;
      col        <= 10'd0;
      row        <= 10'd0;
      for (int i = 0; i < 2; i++) begin
        prev_x[i] <= 8'd0;
        prev_y[i] <= 7'd0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (req != 2'b00) begin
            idx   <= grant_idx;
            cur_x <= grant_idx ? req_x[15:8] : req_x[7:0];
            cur_y <= grant_idx ? req_y[13:7] : req_y[6:0];
            col   <= 10'd0;
            row   <= 10'd0;
          end
        end
        ERASE, DRAW: begin
          if (!flush) begin
            if (last_pix) begin
              col <= 10'd0;
              row <= (state == ERASE) ? 10'd0 : SPR_H10;
            end else if (col == SPR_W10 - 10'd1) begin
              col <= 10'd0;
              row <= row + 10'd1;
            end else begin
              col <= col + 10'd1;
            end
          end
        end
        DONE: begin
          prev_x[idx]     <= cur_x;
          prev_y[idx]     <= cur_y;
          prev_valid[idx] <= 1'b1;
          prio            <= ~idx;
        end
        default: ;
      endcase
    end
  end

  // Plot stage lines up with the one-cycle ROM latency.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      plot_valid <= 1'b0;
      plot_erase <= 1'b0;
      plot_clip  <= 1'b0;
      plot_x     <= 8'd0;
      plot_y     <= 7'd0;
    end else begin
      plot_valid <= sweeping;
      plot_erase <= (state == ERASE);
      if (sweeping) begin
        plot_clip <= clip;
        plot_x    <= px[7:0];
        plot_y    <= py[6:0];
      end
    end
  end

  assign vga_x      = plot_x;
  assign vga_y      = plot_y;
  assign vga_colour = plot_valid ? (plot_erase ? bg_q : spr_q) : 3'b000;
  assign vga_plot   = plot_valid && !plot_clip && (plot_erase || (spr_q != TRANSPARENT));

endmodule
